// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types and helpers for the pipeline sequencing controller.
// Optional feature macro: PIPE_CTRL_FWD_EN (operand forwarding, load-use-only hazards).
package pipe_ctrl_pkg;

    localparam int unsigned TAG_W = 4;
    localparam int unsigned FWD_W = 2;

    typedef enum logic {
        RUN  = 1'b0,
        WAIT = 1'b1
    } state_t;

    typedef logic [FWD_W-1:0] fwd_sel_t;

    localparam fwd_sel_t FWD_RF  = 2'b00;
    localparam fwd_sel_t FWD_MEM = 2'b01;
    localparam fwd_sel_t FWD_WB  = 2'b10;

    // True when an enabled producer writes the register a consumer reads.
    function automatic logic tag_match(
        input logic [TAG_W-1:0] src,
        input logic [TAG_W-1:0] dest,
        input logic             en
    );
        return en & (src == dest);
    endfunction

    // Forwarding source for one operand; the younger MEM result wins over WB.
    function automatic fwd_sel_t fwd_pick(
        input logic [TAG_W-1:0] src,
        input logic [TAG_W-1:0] mem_dest,
        input logic             mem_en,
        input logic [TAG_W-1:0] wb_dest,
        input logic             wb_en
    );
        if (tag_match(src, mem_dest, mem_en)) begin
            return FWD_MEM;
        end else if (tag_match(src, wb_dest, wb_en)) begin
            return FWD_WB;
        end
        return FWD_RF;
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: register tags, branch/memory status and freeze/flush lines
// between the pipeline (master) and the sequencing controller (slave).
interface pipe_ctrl_if
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 16
);

    logic             id_valid;
    logic             id_two_src;
    logic [TAG_W-1:0] id_src1;
    logic [TAG_W-1:0] id_src2;
    logic [TAG_W-1:0] exe_dest;
    logic             exe_wb_en;
    logic             exe_mem_r_en;
    logic [TAG_W-1:0] exe_src1;
    logic [TAG_W-1:0] exe_src2;
    logic [TAG_W-1:0] mem_dest;
    logic             mem_wb_en;
    logic [TAG_W-1:0] wb_dest;
    logic             wb_wb_en;
    logic             branch_taken;
    logic             mem_access;
    logic             sram_ready;

    logic             freeze_pc;
    logic             freeze_ifid;
    logic             flush_ifid;
    logic             flush_idex;
    logic             freeze_back;
    logic             sram_req;
    fwd_sel_t         fwd_sel1;
    fwd_sel_t         fwd_sel2;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output id_valid, id_two_src, id_src1, id_src2,
        output exe_dest, exe_wb_en, exe_mem_r_en, exe_src1, exe_src2,
        output mem_dest, mem_wb_en, wb_dest, wb_wb_en,
        output branch_taken, mem_access, sram_ready,
        input  freeze_pc, freeze_ifid, flush_ifid, flush_idex, freeze_back,
        input  sram_req, fwd_sel1, fwd_sel2, mem_err, stall_cnt
    );

    modport slave (
        input  id_valid, id_two_src, id_src1, id_src2,
        input  exe_dest, exe_wb_en, exe_mem_r_en, exe_src1, exe_src2,
        input  mem_dest, mem_wb_en, wb_dest, wb_wb_en,
        input  branch_taken, mem_access, sram_ready,
        output freeze_pc, freeze_ifid, flush_ifid, flush_idex, freeze_back,
        output sram_req, fwd_sel1, fwd_sel2, mem_err, stall_cnt
    );

endinterface

// File: rtl/pipe_ctrl_hazard_detect.sv
// hazard_detect: combinational tag comparison giving the ID-stage hazard and
// EXE operand forwarding selects. PIPE_CTRL_FWD_EN selects the forwarding build.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic             i_id_valid,
    input  logic             i_id_two_src,
    input  logic [TAG_W-1:0] i_id_src1,
    input  logic [TAG_W-1:0] i_id_src2,
    input  logic [TAG_W-1:0] i_exe_dest,
    input  logic             i_exe_wb_en,
    input  logic             i_exe_mem_r_en,
    input  logic [TAG_W-1:0] i_exe_src1,
    input  logic [TAG_W-1:0] i_exe_src2,
    input  logic [TAG_W-1:0] i_mem_dest,
    input  logic             i_mem_wb_en,
    input  logic [TAG_W-1:0] i_wb_dest,
    input  logic             i_wb_wb_en,
    output logic             o_hazard,
    output fwd_sel_t         o_fwd_sel1,
    output fwd_sel_t         o_fwd_sel2
);

    logic w_exe_hit;

    // ID sources against the EXE-stage destination; src2 only when it is read.
    always_comb begin
        w_exe_hit = tag_match(i_id_src1, i_exe_dest, i_exe_wb_en)
                  | (i_id_two_src & tag_match(i_id_src2, i_exe_dest, i_exe_wb_en));
    end

`ifdef PIPE_CTRL_FWD_EN

    // Results reach EXE by forwarding, so only a load in EXE forces a bubble.
    always_comb begin
        o_hazard   = i_id_valid & i_exe_mem_r_en & w_exe_hit;
        o_fwd_sel1 = fwd_pick(i_exe_src1, i_mem_dest, i_mem_wb_en, i_wb_dest, i_wb_wb_en);
        o_fwd_sel2 = fwd_pick(i_exe_src2, i_mem_dest, i_mem_wb_en, i_wb_dest, i_wb_wb_en);
    end

`else

    logic w_mem_hit;
    logic w_unused_fwd;

    // Without forwarding any in-flight EXE or MEM producer must retire first.
    always_comb begin
        w_mem_hit    = tag_match(i_id_src1, i_mem_dest, i_mem_wb_en)
                     | (i_id_two_src & tag_match(i_id_src2, i_mem_dest, i_mem_wb_en));
        o_hazard     = i_id_valid & (w_exe_hit | w_mem_hit);
        o_fwd_sel1   = FWD_RF;
        o_fwd_sel2   = FWD_RF;
        w_unused_fwd = ^{i_exe_src1, i_exe_src2, i_wb_dest, i_wb_wb_en, i_exe_mem_r_en};
    end

`endif

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline sequencing controller. Decides PC / IF-ID advance, hold
// or flush, ID-EX bubble insertion and owns the SRAM wait handshake that
// freezes the whole pipeline during a MEM-stage access.
// Optional feature macro: PIPE_CTRL_FWD_EN (handled inside hazard_detect).
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 64,
    parameter int unsigned CNT_W       = 16
) (
    input  logic       clk,
    input  logic       rst,
    pipe_ctrl_if.slave bus
);

    localparam int unsigned       TMO_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [TMO_W-1:0] r_tmo_cnt;
    logic [TMO_W-1:0] w_tmo_cnt_nxt;
    logic             r_sram_req;
    logic             w_sram_req_nxt;
    logic             r_mem_err;
    logic             w_mem_err_nxt;
    logic [CNT_W-1:0] r_stall_cnt;

    logic             w_hazard;
    fwd_sel_t         w_fwd_sel1;
    fwd_sel_t         w_fwd_sel2;
    logic             w_freeze_pc;
    logic             w_freeze_ifid;
    logic             w_freeze_back;
    logic             w_flush_ifid;
    logic             w_flush_idex;

    hazard_detect u_hazard_detect (
        .i_id_valid     (bus.id_valid),
        .i_id_two_src   (bus.id_two_src),
        .i_id_src1      (bus.id_src1),
        .i_id_src2      (bus.id_src2),
        .i_exe_dest     (bus.exe_dest),
        .i_exe_wb_en    (bus.exe_wb_en),
        .i_exe_mem_r_en (bus.exe_mem_r_en),
        .i_exe_src1     (bus.exe_src1),
        .i_exe_src2     (bus.exe_src2),
        .i_mem_dest     (bus.mem_dest),
        .i_mem_wb_en    (bus.mem_wb_en),
        .i_wb_dest      (bus.wb_dest),
        .i_wb_wb_en     (bus.wb_wb_en),
        .o_hazard       (w_hazard),
        .o_fwd_sel1     (w_fwd_sel1),
        .o_fwd_sel2     (w_fwd_sel2)
    );

    // State, wait timer, SRAM request and sticky error; reset abandons any access.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= RUN;
            r_tmo_cnt  <= '0;
            r_sram_req <= 1'b0;
            r_mem_err  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_tmo_cnt  <= w_tmo_cnt_nxt;
            r_sram_req <= w_sram_req_nxt;
            r_mem_err  <= w_mem_err_nxt;
        end
    end

    // Next state and priority mux: memory freeze, then branch, then hazard.
    // Every WAIT cycle, including the one that sees ready, keeps the pipe frozen;
    // the stage registers advance on the first cycle back in RUN.
    always_comb begin
        w_state_nxt    = r_state;
        w_tmo_cnt_nxt  = r_tmo_cnt;
        w_sram_req_nxt = r_sram_req;
        w_mem_err_nxt  = r_mem_err;
        w_freeze_pc    = 1'b0;
        w_freeze_ifid  = 1'b0;
        w_freeze_back  = 1'b0;
        w_flush_ifid   = 1'b0;
        w_flush_idex   = 1'b0;

        case (r_state)
            RUN: begin
                if (bus.mem_access) begin
                    w_freeze_pc    = 1'b1;
                    w_freeze_ifid  = 1'b1;
                    w_freeze_back  = 1'b1;
                    w_state_nxt    = WAIT;
                    w_sram_req_nxt = 1'b1;
                    w_tmo_cnt_nxt  = '0;
                end else if (bus.branch_taken) begin
                    w_flush_ifid   = 1'b1;
                    w_flush_idex   = 1'b1;
                end else if (w_hazard) begin
                    w_freeze_pc    = 1'b1;
                    w_freeze_ifid  = 1'b1;
                    w_flush_idex   = 1'b1;
                end
            end

            WAIT: begin
                w_freeze_pc   = 1'b1;
                w_freeze_ifid = 1'b1;
                w_freeze_back = 1'b1;
                if (bus.sram_ready) begin
                    w_state_nxt    = RUN;
                    w_sram_req_nxt = 1'b0;
                end else if (r_tmo_cnt == TMO_LAST) begin
                    w_state_nxt    = RUN;
                    w_sram_req_nxt = 1'b0;
                    w_mem_err_nxt  = 1'b1;
                end else begin
                    w_tmo_cnt_nxt  = r_tmo_cnt + TMO_W'(1);
                end
            end

            default: begin
                w_state_nxt    = RUN;
                w_sram_req_nxt = 1'b0;
            end
        endcase
    end

    // Saturating count of cycles in which the PC is held.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_stall_cnt <= '0;
        end else if (w_freeze_pc && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    // Control lines are forced quiet while reset is held.
    always_comb begin
        bus.freeze_pc   = rst & w_freeze_pc;
        bus.freeze_ifid = rst & w_freeze_ifid;
        bus.freeze_back = rst & w_freeze_back;
        bus.flush_ifid  = rst & w_flush_ifid;
        bus.flush_idex  = rst & w_flush_idex;
        bus.sram_req    = rst & r_sram_req;
        bus.fwd_sel1    = rst ? w_fwd_sel1 : FWD_RF;
        bus.fwd_sel2    = rst ? w_fwd_sel2 : FWD_RF;
        bus.mem_err     = r_mem_err;
        bus.stall_cnt   = r_stall_cnt;
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed scenarios with literal expectations, then randomized
// traffic checked every cycle against a behavioural model of the controller.
module tb_pipe_ctrl;

    localparam int unsigned TMO       = 4;
    localparam int unsigned CW        = 6;
    localparam int          STALL_MAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst;
    bit   checking = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    // Model state: an access outstanding, its wait age, sticky error, stall count.
    bit   m_busy  = 1'b0;
    int   m_age   = 0;
    bit   m_err   = 1'b0;
    int   m_stall = 0;

    pipe_ctrl_if #(.CNT_W(CW)) bus ();

    pipe_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Any source the ID instruction reads that a blocking producer writes.
    function automatic bit model_hazard();
        int srcs[2];
        bit reads[2];
        bit hz = 1'b0;
        srcs[0]  = int'(bus.id_src1);
        srcs[1]  = int'(bus.id_src2);
        reads[0] = bus.id_valid;
        reads[1] = bus.id_valid && bus.id_two_src;
        for (int s = 0; s < 2; s++) begin
            if (reads[s]) begin
`ifdef PIPE_CTRL_FWD_EN
                if (bus.exe_mem_r_en && bus.exe_wb_en && srcs[s] == int'(bus.exe_dest)) hz = 1'b1;
`else
                if (bus.exe_wb_en && srcs[s] == int'(bus.exe_dest)) hz = 1'b1;
                if (bus.mem_wb_en && srcs[s] == int'(bus.mem_dest)) hz = 1'b1;
`endif
            end
        end
        return hz;
    endfunction

    function automatic int model_fwd(input int src);
`ifdef PIPE_CTRL_FWD_EN
        if (bus.mem_wb_en && src == int'(bus.mem_dest)) return 1;
        if (bus.wb_wb_en && src == int'(bus.wb_dest)) return 2;
`endif
        return 0 * src;
    endfunction

    // Compare process: checks every output mid-cycle, then advances the model.
    always @(negedge clk) begin
        if (checking) begin
            bit on, frz, br, hz;
            on  = (rst === 1'b1);
            frz = on && (m_busy || bus.mem_access);
            br  = on && !frz && bus.branch_taken;
            hz  = on && !frz && !bus.branch_taken && model_hazard();
            chk("m_freeze_pc",   32'(bus.freeze_pc),   32'(frz || hz));
            chk("m_freeze_ifid", 32'(bus.freeze_ifid), 32'(frz || hz));
            chk("m_freeze_back", 32'(bus.freeze_back), 32'(frz));
            chk("m_flush_ifid",  32'(bus.flush_ifid),  32'(br));
            chk("m_flush_idex",  32'(bus.flush_idex),  32'(br || hz));
            chk("m_sram_req",    32'(bus.sram_req),    32'(on && m_busy));
            chk("m_fwd_sel1",    32'(bus.fwd_sel1),    on ? 32'(model_fwd(int'(bus.exe_src1))) : 32'd0);
            chk("m_fwd_sel2",    32'(bus.fwd_sel2),    on ? 32'(model_fwd(int'(bus.exe_src2))) : 32'd0);
            chk("m_mem_err",     32'(bus.mem_err),     32'(m_err));
            chk("m_stall_cnt",   32'(bus.stall_cnt),   32'(m_stall));
            if (!on) begin
                m_busy = 1'b0; m_age = 0; m_err = 1'b0; m_stall = 0;
            end else begin
                if ((frz || hz) && m_stall < STALL_MAX) m_stall++;
                if (m_busy) begin
                    if (bus.sram_ready) m_busy = 1'b0;
                    else if (m_age == int'(TMO) - 1) begin m_err = 1'b1; m_busy = 1'b0; end
                    else m_age++;
                end else if (bus.mem_access) begin
                    m_busy = 1'b1;
                    m_age  = 0;
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.id_valid = 0; bus.id_two_src = 0; bus.id_src1 = 0; bus.id_src2 = 0;
        bus.exe_dest = 0; bus.exe_wb_en = 0; bus.exe_mem_r_en = 0;
        bus.exe_src1 = 0; bus.exe_src2 = 0;
        bus.mem_dest = 0; bus.mem_wb_en = 0; bus.wb_dest = 0; bus.wb_wb_en = 0;
        bus.branch_taken = 0; bus.mem_access = 0; bus.sram_ready = 0;
    endtask

    task automatic load_hazard_r3();
        bus.id_valid = 1; bus.id_src1 = 4'd3; bus.exe_dest = 4'd3;
        bus.exe_wb_en = 1; bus.exe_mem_r_en = 1;
    endtask

    initial begin
        int frz_n, req_n, bad_n;
        rst = 1'b0;
        idle();
        next_cycle();
        checking = 1'b1;

        // Reset holds all control lines low even with requests present.
        bus.mem_access = 1; bus.branch_taken = 1; load_hazard_r3();
        #2;
        chk("rst_freeze_pc",  32'(bus.freeze_pc),  32'd0);
        chk("rst_flush_ifid", 32'(bus.flush_ifid), 32'd0);
        next_cycle();
        rst = 1'b1; idle();
        #2;
        chk("rst_stall_cnt", 32'(bus.stall_cnt), 32'd0);
        chk("rst_mem_err",   32'(bus.mem_err),   32'd0);
        chk("rst_sram_req",  32'(bus.sram_req),  32'd0);

        // Single-cycle bubble for a dependency on EXE.
        next_cycle(); load_hazard_r3(); #2;
        chk("hz_freeze_pc",   32'(bus.freeze_pc),   32'd1);
        chk("hz_freeze_ifid", 32'(bus.freeze_ifid), 32'd1);
        chk("hz_flush_idex",  32'(bus.flush_idex),  32'd1);
        chk("hz_flush_ifid",  32'(bus.flush_ifid),  32'd0);
        next_cycle(); idle(); #2;
        chk("hz_release",   32'(bus.freeze_pc), 32'd0);
        chk("hz_stall_cnt", 32'(bus.stall_cnt), 32'd1);

        // Branch beats hazard.
        next_cycle(); load_hazard_r3(); bus.branch_taken = 1; #2;
        chk("br_flush_ifid", 32'(bus.flush_ifid), 32'd1);
        chk("br_flush_idex", 32'(bus.flush_idex), 32'd1);
        chk("br_freeze_pc",  32'(bus.freeze_pc),  32'd0);

        // Load-use versus plain producer, and forwarding selects.
        next_cycle(); idle();
        bus.id_valid = 1; bus.id_two_src = 1; bus.id_src2 = 4'd5;
        bus.exe_dest = 4'd5; bus.exe_wb_en = 1; bus.exe_mem_r_en = 1; #2;
        chk("lu_load_stall", 32'(bus.freeze_pc), 32'd1);
        next_cycle(); bus.exe_mem_r_en = 0; #2;
`ifdef PIPE_CTRL_FWD_EN
        chk("lu_alu_nostall", 32'(bus.freeze_pc), 32'd0);
`else
        chk("lu_alu_stall", 32'(bus.freeze_pc), 32'd1);
`endif
        next_cycle(); bus.id_two_src = 0; #2;
        chk("lu_src2_unread", 32'(bus.freeze_pc), 32'd0);
        next_cycle(); idle();
        bus.exe_src1 = 4'd5; bus.mem_dest = 4'd5; bus.mem_wb_en = 1;
        bus.wb_dest = 4'd5; bus.wb_wb_en = 1; #2;
`ifdef PIPE_CTRL_FWD_EN
        chk("fwd_mem_wins", 32'(bus.fwd_sel1), 32'd1);
        next_cycle(); bus.mem_wb_en = 0; #2;
        chk("fwd_wb", 32'(bus.fwd_sel1), 32'd2);
`else
        chk("fwd_tied_rf", 32'(bus.fwd_sel1), 32'd0);
`endif

        // Access with ready three cycles after detect; branch held throughout.
        next_cycle(); idle();
        frz_n = 0; req_n = 0; bad_n = 0;
        for (int c = 0; c < 6; c++) begin
            next_cycle();
            bus.mem_access = (c == 0); bus.sram_ready = (c == 3); bus.branch_taken = 1;
            #2;
            frz_n += int'(bus.freeze_pc);
            req_n += int'(bus.sram_req);
            if (bus.freeze_back && bus.flush_ifid) bad_n++;
            if (c == 4) begin
                chk("mw_release_flush", 32'(bus.flush_ifid), 32'd1);
                chk("mw_release_pc",    32'(bus.freeze_pc),  32'd0);
            end
        end
        chk("mw_frozen_cycles", 32'(frz_n), 32'd4);
        chk("mw_req_cycles",    32'(req_n), 32'd3);
        chk("mw_flush_in_wait", 32'(bad_n), 32'd0);

        // Timeout without ready.
        next_cycle(); idle();
        frz_n = 0;
        for (int c = 0; c < 8; c++) begin
            next_cycle();
            bus.mem_access = (c == 0);
            #2;
            frz_n += int'(bus.freeze_back);
            if (c == 4) chk("to_err_pending", 32'(bus.mem_err), 32'd0);
            if (c == 5) begin
                chk("to_err_set", 32'(bus.mem_err),   32'd1);
                chk("to_release", 32'(bus.freeze_pc), 32'd0);
            end
        end
        chk("to_frozen_cycles", 32'(frz_n),       32'd5);
        chk("to_err_sticky",    32'(bus.mem_err), 32'd1);
        next_cycle(); rst = 1'b0;
        next_cycle(); rst = 1'b1; #2;
        chk("to_err_cleared", 32'(bus.mem_err), 32'd0);

        // Reset during WAIT abandons the access.
        next_cycle(); bus.mem_access = 1;
        next_cycle(); bus.mem_access = 0; #2;
        chk("rw_in_wait", 32'(bus.sram_req), 32'd1);
        next_cycle(); rst = 1'b0; #2;
        chk("rw_req_gated", 32'(bus.sram_req), 32'd0);
        next_cycle(); rst = 1'b1; #2;
        chk("rw_req",       32'(bus.sram_req),    32'd0);
        chk("rw_freeze",    32'(bus.freeze_back), 32'd0);
        chk("rw_stall_cnt", 32'(bus.stall_cnt),   32'd0);

        // Stall counter saturates.
        for (int c = 0; c < STALL_MAX + 8; c++) begin
            next_cycle(); load_hazard_r3();
        end
        next_cycle(); idle(); #2;
        chk("sat_stall_cnt", 32'(bus.stall_cnt), 32'(STALL_MAX));

        // Randomized traffic; the compare process does the checking.
        for (int c = 0; c < 3000; c++) begin
            next_cycle();
            rst              = ($urandom_range(0, 63) != 0);
            bus.id_valid     = 1'($urandom_range(0, 3) != 0);
            bus.id_two_src   = 1'($urandom_range(0, 1));
            bus.id_src1      = 4'($urandom_range(0, 5));
            bus.id_src2      = 4'($urandom_range(0, 5));
            bus.exe_dest     = 4'($urandom_range(0, 5));
            bus.exe_wb_en    = 1'($urandom_range(0, 1));
            bus.exe_mem_r_en = 1'($urandom_range(0, 1));
            bus.exe_src1     = 4'($urandom_range(0, 5));
            bus.exe_src2     = 4'($urandom_range(0, 5));
            bus.mem_dest     = 4'($urandom_range(0, 5));
            bus.mem_wb_en    = 1'($urandom_range(0, 1));
            bus.wb_dest      = 4'($urandom_range(0, 5));
            bus.wb_wb_en     = 1'($urandom_range(0, 1));
            bus.branch_taken = ($urandom_range(0, 5) == 0);
            bus.mem_access   = ($urandom_range(0, 7) == 0);
            bus.sram_ready   = ($urandom_range(0, 2) == 0);
        end
        next_cycle();
        @(negedge clk);
        #1;
        checking = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
